// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encoding
// and the ordering of the pipeline control-output bundle.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_BR_WAIT  = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    // Control bundle, MSB first: pc_write, if_id_write, id_ex_write,
    // if_id_flush, id_ex_bubble.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_PASS  = 5'b11100;
    localparam ctrl_t CTRL_HOLD  = 5'b00000;
    localparam ctrl_t CTRL_FLUSH = 5'b11110;

    // Load-use stall pattern: full freeze, or freeze front end and bubble ID/EX.
    function automatic ctrl_t ld_stall_ctrl(input logic bubble_mode);
        ctrl_t c;
        if (bubble_mode) begin
            c = 5'b00101;
        end else begin
            c = 5'b00000;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register with async clear, sync clear and saturation at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != '1)) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: drives PC, IF/ID and ID/EX write-enables and
// flush/bubble controls from load-use detection and branch resolution.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter int LOAD_LAT    = 1,
    parameter int BUBBLE_MODE = 0,
    parameter int BR_WAIT_MAX = 7,
    parameter int CNT_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  halt,
    input  logic                  br_id,
    input  logic                  br_resolved,
    input  logic                  br_taken,
    input  logic                  mem_read_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  use_rs_id,
    input  logic                  use_rt_id,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  halted,
    output logic                  br_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [3:0] LD_INIT = 4'(LOAD_LAT - 1);
    localparam logic [7:0] BR_LAST = 8'(BR_WAIT_MAX - 1);
    localparam ctrl_t      CTRL_LD = ld_stall_ctrl(BUBBLE_MODE != 0);

    state_e     state_r, state_s;
    logic [3:0] ld_cnt_r, ld_cnt_s;
    logic [7:0] br_cnt_r, br_cnt_s;
    logic       ld_mask_r, ld_mask_s;
    logic       halted_r, halted_s;
    logic       br_timeout_r, br_timeout_s;
    ctrl_t      ctrl_s;
    logic       hz_s;
    logic       stall_inc_s;
    logic       flush_inc_s;

    assign hz_s = mem_read_ex & ((use_rs_id & (rs_id == rd_ex)) |
                                 (use_rt_id & (rt_id == rd_ex)));

    // Next-state and control-output decode; priority run=0, halt, state action.
    always_comb begin
        state_s      = state_r;
        ld_cnt_s     = ld_cnt_r;
        br_cnt_s     = br_cnt_r;
        ld_mask_s    = ld_mask_r;
        halted_s     = halted_r;
        br_timeout_s = br_timeout_r;
        ctrl_s       = CTRL_PASS;
        if (!run) begin
            ctrl_s = CTRL_HOLD;
        end else if (halt) begin
            ctrl_s   = CTRL_HOLD;
            state_s  = ST_HALT;
            halted_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (br_id) begin
                        ld_mask_s = 1'b0;
                        if (br_resolved) begin
                            ctrl_s = br_taken ? CTRL_FLUSH : CTRL_PASS;
                        end else begin
                            ctrl_s   = CTRL_HOLD;
                            state_s  = ST_BR_WAIT;
                            br_cnt_s = 8'd0;
                        end
                    end else if (hz_s && !ld_mask_r) begin
                        ctrl_s = CTRL_LD;
                        if (LOAD_LAT > 1) begin
                            state_s  = ST_LD_STALL;
                            ld_cnt_s = LD_INIT;
                        end else begin
                            ld_mask_s = 1'b1;
                        end
                    end else begin
                        ld_mask_s = 1'b0;
                    end
                end
                ST_LD_STALL: begin
                    ctrl_s = CTRL_LD;
                    if (ld_cnt_r <= 4'd1) begin
                        state_s   = ST_RUN;
                        ld_mask_s = 1'b1;
                    end else begin
                        ld_cnt_s = ld_cnt_r - 4'd1;
                    end
                end
                ST_BR_WAIT: begin
                    if (br_resolved) begin
                        ctrl_s  = br_taken ? CTRL_FLUSH : CTRL_PASS;
                        state_s = ST_RUN;
                    end else if (br_cnt_r >= BR_LAST) begin
                        ctrl_s       = CTRL_PASS;
                        br_timeout_s = 1'b1;
                        state_s      = ST_RUN;
                    end else begin
                        ctrl_s   = CTRL_HOLD;
                        br_cnt_s = br_cnt_r + 8'd1;
                    end
                end
                ST_HALT: begin
                    ctrl_s = CTRL_HOLD;
                end
                default: begin
                    ctrl_s  = CTRL_HOLD;
                    state_s = ST_RUN;
                end
            endcase
        end
    end

    assign stall_inc_s = run & ~ctrl_s.pc_write & ~halt & (state_r != ST_HALT);
    assign flush_inc_s = run & ctrl_s.if_id_flush;

    // FSM and status registers; async reset returns to RUN with everything clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_RUN;
            ld_cnt_r     <= 4'd0;
            br_cnt_r     <= 8'd0;
            ld_mask_r    <= 1'b0;
            halted_r     <= 1'b0;
            br_timeout_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            ld_cnt_r     <= ld_cnt_s;
            br_cnt_r     <= br_cnt_s;
            ld_mask_r    <= ld_mask_s;
            halted_r     <= halted_s;
            br_timeout_r <= br_timeout_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

    // Control outputs are forced low while reset is asserted.
    assign pc_write     = reset & ctrl_s.pc_write;
    assign if_id_write  = reset & ctrl_s.if_id_write;
    assign id_ex_write  = reset & ctrl_s.id_ex_write;
    assign if_id_flush  = reset & ctrl_s.if_id_flush;
    assign id_ex_bubble = reset & ctrl_s.id_ex_bubble;
    assign halted       = halted_r;
    assign br_timeout   = br_timeout_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (LOAD_LAT=3, bubble mode,
// BR_WAIT_MAX=7, 4-bit counters).
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       run, halt, br_id, br_resolved, br_taken, mem_read_ex;
    logic [2:0] rd_ex, rs_id, rt_id;
    logic       use_rs_id, use_rt_id;
    logic       pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble;
    logic       halted, br_timeout;
    logic [3:0] stall_cnt, flush_cnt;
    logic [4:0] ctl;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [4:0] E_PASS  = 5'b11100;
    localparam logic [4:0] E_HOLD  = 5'b00000;
    localparam logic [4:0] E_FLUSH = 5'b11110;
    localparam logic [4:0] E_LD    = 5'b00101;

    hazard_ctrl #(
        .REG_ADDR_W  (3),
        .LOAD_LAT    (3),
        .BUBBLE_MODE (1),
        .BR_WAIT_MAX (7),
        .CNT_W       (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .halt         (halt),
        .br_id        (br_id),
        .br_resolved  (br_resolved),
        .br_taken     (br_taken),
        .mem_read_ex  (mem_read_ex),
        .rd_ex        (rd_ex),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .use_rs_id    (use_rs_id),
        .use_rt_id    (use_rt_id),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_write  (id_ex_write),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .halted       (halted),
        .br_timeout   (br_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign ctl = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble};

    always #5 clock = ~clock;

    task automatic set_idle();
        run = 1'b1; halt = 1'b0; br_id = 1'b0; br_resolved = 1'b0; br_taken = 1'b0;
        mem_read_ex = 1'b0; rd_ex = 3'd0; rs_id = 3'd0; rt_id = 3'd0;
        use_rs_id = 1'b0; use_rt_id = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic set_hazard_rs();
        mem_read_ex = 1'b1; rd_ex = 3'd2; rs_id = 3'd2; use_rs_id = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_HOLD) begin
            tests_failed++; $display("FAIL reset_ctl got=%b exp=%b", ctl, E_HOLD);
        end
        tests_run++;
        if ({halted, br_timeout, stall_cnt, flush_cnt} !== 10'd0) begin
            tests_failed++; $display("FAIL reset_status got=%b exp=0", {halted, br_timeout, stall_cnt, flush_cnt});
        end
        reset = 1'b1;
        next_cycle();
        @(negedge clock);
        tests_run++;
        if (ctl !== E_PASS) begin
            tests_failed++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, E_PASS);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_hazard_rs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if (ctl !== E_LD) begin
                tests_failed++; $display("FAIL ld_stall_%0d got=%b exp=%b", i, ctl, E_LD);
            end
            next_cycle();
        end
        @(negedge clock);
        tests_run++;
        if (ctl !== E_PASS) begin
            tests_failed++; $display("FAIL ld_masked got=%b exp=%b", ctl, E_PASS);
        end
        tests_run++;
        if (stall_cnt !== 4'd3) begin
            tests_failed++; $display("FAIL ld_stall_cnt got=%0d exp=3", stall_cnt);
        end
        next_cycle();
        @(negedge clock);
        tests_run++;
        if (ctl !== E_LD) begin
            tests_failed++; $display("FAIL ld_redetect got=%b exp=%b", ctl, E_LD);
        end
        // Register 0 via rt is not exempt
        do_reset();
        mem_read_ex = 1'b1; rd_ex = 3'd0; rt_id = 3'd0; use_rt_id = 1'b1; rs_id = 3'd5; use_rs_id = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_LD) begin
            tests_failed++; $display("FAIL ld_rt_r0 got=%b exp=%b", ctl, E_LD);
        end
        // Matching address but not read: no hazard
        do_reset();
        mem_read_ex = 1'b1; rd_ex = 3'd4; rt_id = 3'd4; use_rt_id = 1'b0;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_PASS) begin
            tests_failed++; $display("FAIL ld_unused_src got=%b exp=%b", ctl, E_PASS);
        end
        next_cycle();
    endtask

    task automatic test_branch_taken();
        do_reset();
        br_id = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            tests_run++;
            if (ctl !== E_HOLD) begin
                tests_failed++; $display("FAIL br_wait_%0d got=%b exp=%b", i, ctl, E_HOLD);
            end
            next_cycle();
        end
        br_resolved = 1'b1; br_taken = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_FLUSH) begin
            tests_failed++; $display("FAIL br_taken got=%b exp=%b", ctl, E_FLUSH);
        end
        next_cycle();
        br_id = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd2}) begin
            tests_failed++; $display("FAIL br_counts got=%0d/%0d exp=1/2", flush_cnt, stall_cnt);
        end
        tests_run++;
        if (ctl !== E_PASS) begin
            tests_failed++; $display("FAIL br_late_resolve got=%b exp=%b", ctl, E_PASS);
        end
        next_cycle();
        // Not-taken resolution from BR_WAIT
        br_id = 1'b1; br_resolved = 1'b0; br_taken = 1'b0;
        next_cycle();
        br_id = 1'b0; br_resolved = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_PASS) begin
            tests_failed++; $display("FAIL br_not_taken got=%b exp=%b", ctl, E_PASS);
        end
        next_cycle();
        // Branch resolved in the same cycle it appears: flush, stay in RUN
        br_id = 1'b1; br_resolved = 1'b1; br_taken = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_FLUSH) begin
            tests_failed++; $display("FAIL br_same_cycle got=%b exp=%b", ctl, E_FLUSH);
        end
        next_cycle();
        set_idle();
        @(negedge clock);
        tests_run++;
        if ({ctl, flush_cnt} !== {E_PASS, 4'd2}) begin
            tests_failed++; $display("FAIL br_same_cycle_after got=%b/%0d exp=%b/2", ctl, flush_cnt, E_PASS);
        end
        next_cycle();
    endtask

    task automatic test_branch_timeout();
        do_reset();
        br_id = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_HOLD) begin
            tests_failed++; $display("FAIL to_enter got=%b exp=%b", ctl, E_HOLD);
        end
        next_cycle();
        br_id = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            tests_run++;
            if (ctl !== E_HOLD) begin
                tests_failed++; $display("FAIL to_wait_%0d got=%b exp=%b", i, ctl, E_HOLD);
            end
            tests_run++;
            if (br_timeout !== 1'b0) begin
                tests_failed++; $display("FAIL to_early_flag_%0d got=%b exp=0", i, br_timeout);
            end
            next_cycle();
        end
        @(negedge clock);
        tests_run++;
        if (ctl !== E_PASS) begin
            tests_failed++; $display("FAIL to_release got=%b exp=%b", ctl, E_PASS);
        end
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clock);
        tests_run++;
        if ({br_timeout, stall_cnt, flush_cnt} !== {1'b1, 4'd7, 4'd0}) begin
            tests_failed++; $display("FAIL to_status got=%b/%0d/%0d exp=1/7/0", br_timeout, stall_cnt, flush_cnt);
        end
        next_cycle();
    endtask

    task automatic test_br_hz_halt();
        do_reset();
        set_hazard_rs();
        br_id = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_HOLD) begin
            tests_failed++; $display("FAIL brhz_priority got=%b exp=%b", ctl, E_HOLD);
        end
        next_cycle();
        br_id = 1'b0;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_HOLD) begin
            tests_failed++; $display("FAIL brhz_in_wait got=%b exp=%b", ctl, E_HOLD);
        end
        next_cycle();
        halt = 1'b1;
        next_cycle();
        halt = 1'b0; br_resolved = 1'b1; br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if ({ctl, halted} !== {E_HOLD, 1'b1}) begin
                tests_failed++; $display("FAIL halt_hold_%0d got=%b/%b exp=%b/1", i, ctl, halted, E_HOLD);
            end
            next_cycle();
        end
    endtask

    task automatic test_run_low();
        do_reset();
        set_hazard_rs();
        next_cycle();
        next_cycle();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tests_run++;
            if ({ctl, stall_cnt} !== {E_HOLD, 4'd2}) begin
                tests_failed++; $display("FAIL runlow_%0d got=%b/%0d exp=%b/2", i, ctl, stall_cnt, E_HOLD);
            end
            next_cycle();
        end
        run = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ctl !== E_LD) begin
            tests_failed++; $display("FAIL runlow_resume got=%b exp=%b", ctl, E_LD);
        end
        next_cycle();
        @(negedge clock);
        tests_run++;
        if ({ctl, stall_cnt} !== {E_PASS, 4'd3}) begin
            tests_failed++; $display("FAIL runlow_done got=%b/%0d exp=%b/3", ctl, stall_cnt, E_PASS);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        br_id = 1'b1;
        next_cycle();
        br_id = 1'b0;
        next_cycle();
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({ctl, stall_cnt} !== {E_HOLD, 4'd0}) begin
            tests_failed++; $display("FAIL rst_async got=%b/%0d exp=%b/0", ctl, stall_cnt, E_HOLD);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ctl, stall_cnt, flush_cnt, br_timeout} !== {E_PASS, 4'd0, 4'd0, 1'b0}) begin
            tests_failed++; $display("FAIL rst_release got=%b/%0d/%0d/%b exp=%b/0/0/0", ctl, stall_cnt, flush_cnt, br_timeout, E_PASS);
        end
        next_cycle();
        @(negedge clock);
        tests_run++;
        if (ctl !== E_PASS) begin
            tests_failed++; $display("FAIL rst_run_after got=%b exp=%b", ctl, E_PASS);
        end
        next_cycle();
    endtask

    task automatic test_saturate();
        do_reset();
        set_hazard_rs();
        for (int i = 0; i < 16; i++) next_cycle();
        @(negedge clock);
        tests_run++;
        if (stall_cnt !== 4'd12) begin
            tests_failed++; $display("FAIL sat_mid got=%0d exp=12", stall_cnt);
        end
        for (int i = 0; i < 12; i++) next_cycle();
        @(negedge clock);
        tests_run++;
        if (stall_cnt !== 4'hF) begin
            tests_failed++; $display("FAIL sat_full got=%0d exp=15", stall_cnt);
        end
        next_cycle();
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        test_reset();
        test_load_use();
        test_branch_taken();
        test_branch_timeout();
        test_br_hz_halt();
        test_run_low();
        test_reset_mid_wait();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
